// File: rtl/pi_loop_filter_gs.sv
// pi_loop_filter_gs: gear-shifted PI loop filter with deadband, rounding shifts,
// integrator anti-windup and a windowed mean-|e| lock detector (ACQ/TRACK).
module pi_loop_filter_gs #(
    parameter int WERR          = 18,
    parameter int ACC_WIDTH     = 24,
    parameter int DB_THRESH     = 128,
    parameter int LOCK_WIN      = 64,
    parameter int LOCK_THRESH   = 200,
    parameter int UNLOCK_THRESH = 400,
    parameter int LOCK_CNT      = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic signed [WERR-1:0] e_in_i,
    input  logic                   e_valid_i,
    input  logic [4:0]             kp_acq_i,
    input  logic [4:0]             ki_acq_i,
    input  logic [4:0]             kp_trk_i,
    input  logic [4:0]             ki_trk_i,
    input  logic                   freeze_i,
    input  logic                   int_clr_i,
    output logic signed [WERR-1:0] ctrl_o,
    output logic                   ctrl_val_o,
    output logic                   locked_o,
    output logic                   sat_o
);
    localparam int LW = LOCK_WIN > 1 ? $clog2(LOCK_WIN) : 1;
    localparam int SW = WERR + LW;
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int AW = ACC_WIDTH + 2;
    localparam logic signed [AW-1:0] AMAX = {3'b000, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] CMAX = {{(AW-WERR+1){1'b0}}, {(WERR-1){1'b1}}};
    localparam logic [SW-1:0] LOCK_SUM = SW'(LOCK_THRESH * LOCK_WIN);
    localparam logic [SW-1:0] UNLOCK_SUM = SW'(UNLOCK_THRESH * LOCK_WIN);

    typedef enum logic {ACQ, TRACK} state_t;

    state_t state, state_nx;
    logic [GW-1:0] good, good_nx;
    logic [SW-1:0] win_sum, win_sum_nx, full;
    logic [LW-1:0] win_cnt, win_cnt_nx;
    logic last, hold, trk;
    logic signed [ACC_WIDTH-1:0] acc, acc_nx;
    logic signed [WERR:0] e_x, e_db, p, i;
    logic [WERR:0] mag;
    logic [WERR-1:0] mag_l;
    logic signed [AW-1:0] acc_raw, acc_c, sum_c, sum_o, sum, clip;

    function automatic logic signed [WERR:0] rnd(input logic signed [WERR:0] e, input logic [4:0] k);
        logic [4:0] kk;
        logic [WERR:0] m, r;
        kk = (int'(k) >= WERR) ? 5'(WERR - 1) : k;
        m = e[WERR] ? -e : e;
        r = (m + ((WERR+1)'(1) << (kk - 5'd1))) >> kk;
        return (kk == 5'd0) ? e : (e[WERR] ? -$signed(r) : $signed(r));
    endfunction

    always_comb begin
        e_x = (WERR+1)'(e_in_i);
        mag = e_x[WERR] ? -e_x : e_x;
        mag_l = mag[WERR-1] ? {1'b0, {(WERR-1){1'b1}}} : mag[WERR-1:0];
        e_db = (mag < (WERR+1)'(DB_THRESH)) ? '0 : e_x;
        trk = state == TRACK;
        p = freeze_i ? '0 : rnd(e_db, trk ? kp_trk_i : kp_acq_i);
        i = rnd(e_db, trk ? ki_trk_i : ki_acq_i);
        acc_raw = AW'(acc) + AW'(i);
        acc_c = acc_raw > AMAX ? AMAX : acc_raw < -AMAX ? -AMAX : acc_raw;
        sum_c = AW'(p) + acc_c;
        sum_o = AW'(p) + AW'(acc);
        // anti-windup: integrating further in the direction of saturation is refused
        hold = !int_clr_i && !freeze_i && (sum_c > CMAX || sum_c < -CMAX) && i != '0 && i[WERR] == sum_c[AW-1];
        sum = int_clr_i ? AW'(p) : (freeze_i || hold) ? sum_o : sum_c;
        clip = sum > CMAX ? CMAX : sum < -CMAX ? -CMAX : sum;
        acc_nx = int_clr_i ? '0 : (e_valid_i && !freeze_i && !hold) ? acc_c[ACC_WIDTH-1:0] : acc;
    end

    always_comb begin
        state_nx = state;
        good_nx = good;
        win_sum_nx = win_sum;
        win_cnt_nx = win_cnt;
        full = win_sum + SW'(mag_l);
        last = win_cnt == LW'(LOCK_WIN - 1);
        if (e_valid_i && !freeze_i) begin
            win_sum_nx = last ? '0 : full;
            win_cnt_nx = last ? '0 : win_cnt + 1'b1;
            if (last && state == ACQ) begin
                good_nx = (full < LOCK_SUM) ? good + 1'b1 : '0;
                if (good_nx == GW'(LOCK_CNT)) begin
                    state_nx = TRACK;
                    good_nx = '0;
                end
            end else if (last && full > UNLOCK_SUM) begin
                state_nx = ACQ;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ACQ;
            good <= '0;
            win_sum <= '0;
            win_cnt <= '0;
            acc <= '0;
            ctrl_o <= '0;
            ctrl_val_o <= 1'b0;
            sat_o <= 1'b0;
            locked_o <= 1'b0;
        end else begin
            state <= state_nx;
            good <= good_nx;
            win_sum <= win_sum_nx;
            win_cnt <= win_cnt_nx;
            acc <= acc_nx;
            locked_o <= state_nx == TRACK;
            ctrl_val_o <= e_valid_i;
            if (e_valid_i) begin
                ctrl_o <= clip[WERR-1:0];
                sat_o <= hold || clip != sum;
            end
        end
    end
endmodule
